sha1_msg_schedule: RTL and testbench

//  Sequential SHA-1/SHA-0 message-schedule generator: accepts one 512-bit padded block, streams W[0..ROUNDS-1].

---
 rtl/sha1_msg_schedule.sv | 138 +++++++++++++
 tb/tb_sha1_msg_schedule.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_schedule.sv
// SHA-1 / SHA-0 message-schedule generator: loads one 512-bit block into a 16-word
// sliding window and streams W[0..ROUNDS-1], WPC words per beat, over valid/ready.
module sha1_msg_schedule #(
  parameter int WPC    = 1,
  parameter int ROUNDS = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [511:0]      in_block,
  input  logic              in_mode,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*WPC-1:0] out_w,
  output logic [6:0]        out_t,
  output logic              out_last
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [6:0] T_STEP = 7'(WPC);
  localparam logic [6:0] T_LAST = 7'(ROUNDS - WPC);

  state_e      state_q;
  logic        mode_q;
  logic        out_valid_q;
  logic [6:0]  out_t_q;
  logic        out_last_q;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] new_w [WPC];

  logic load;
  logic advance;

  // Abort wins over both a new block and a beat handshake in the same cycle.
  assign load    = (state_q == ST_IDLE) && in_valid && !abort;
  assign advance = (state_q == ST_EMIT) && out_valid_q && out_ready && !out_last_q && !abort;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    for (int k = 0; k < WPC; k++) begin
      new_w[k] = win_q[13+k] ^ win_q[8+k] ^ win_q[2+k] ^ win_q[k];
      if (!mode_q) begin
        new_w[k] = {new_w[k][30:0], new_w[k][31]};
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = in_block[511-32*i -: 32];
      end
    end else if (advance) begin
      for (int i = 0; i < 16 - WPC; i++) begin
        win_d[i] = win_q[i+WPC];
      end
      for (int k = 0; k < WPC; k++) begin
        win_d[16-WPC+k] = new_w[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_t_q     <= '0;
      out_last_q  <= 1'b0;
      // NOTE: the window is reset even though it is storage, because out_w is read
      // straight from its low words and must be zero out of reset.
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      win_q <= win_d;
      if (abort) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        out_t_q     <= '0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_valid) begin
              state_q     <= ST_EMIT;
              mode_q      <= in_mode;
              out_valid_q <= 1'b1;
              out_t_q     <= '0;
              out_last_q  <= (T_LAST == 7'd0);
            end
          end
          ST_EMIT: begin
            if (out_valid_q && out_ready) begin
              if (out_last_q) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end else begin
                out_t_q    <= out_t_q + T_STEP;
                out_last_q <= ((out_t_q + T_STEP) == T_LAST);
              end
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    out_w = '0;
    for (int k = 0; k < WPC; k++) begin
      out_w[32*k +: 32] = win_q[k];
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_t     = out_t_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// Directed bench for sha1_msg_schedule: one WPC=1 and one WPC=2 instance, compared
// against hand-computed "abc" words and an independent textbook schedule model.
module tb_sha1_msg_schedule;

  logic         clk = 1'b0;
  logic         reset;

  logic         in_valid, in_ready, in_mode, abort, out_valid, out_ready, out_last;
  logic [511:0] in_block;
  logic [31:0]  out_w;
  logic [6:0]   out_t;

  logic         in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [511:0] in_block2;
  logic [63:0]  out_w2;
  logic [6:0]   out_t2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] gw  [80];
  logic [31:0] cap [80];

  always #5 clk = ~clk;

  sha1_msg_schedule #(.WPC(1), .ROUNDS(80)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_mode(in_mode), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_w(out_w), .out_t(out_t), .out_last(out_last)
  );

  sha1_msg_schedule #(.WPC(2), .ROUNDS(80)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_block(in_block2), .in_mode(1'b0), .abort(1'b0), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_w(out_w2), .out_t(out_t2), .out_last(out_last2)
  );

  // Textbook schedule: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) (no rotate for SHA-0).
  task automatic build_gold(input logic [511:0] blk, input logic mode);
    logic [31:0] x;
    for (int i = 0; i < 16; i++) gw[i] = blk[511-32*i -: 32];
    for (int t = 16; t < 80; t++) begin
      x = gw[t-3] ^ gw[t-8] ^ gw[t-14] ^ gw[t-16];
      gw[t] = mode ? x : {x[30:0], x[31]};
    end
  endtask

  function automatic logic [511:0] abc_block();
    logic [511:0] b;
    b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    return b;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction

  // Caller is at a negedge with dut1 idle; returns at the negedge after accept.
  task automatic send_block(input logic [511:0] blk, input logic mode);
    build_gold(blk, mode);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    end
    in_block = blk; in_mode = mode; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_block = '0; in_mode = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_t !== 7'd0) begin
      failures++; $display("FAIL first_beat: out_valid=%b out_t=%0d want 1/0", out_valid, out_t);
    end
  endtask

  // Checks beats against gw; stops early (without handshaking) when t == stop_at.
  task automatic run_stream(input int stop_at, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit exp_last;
    while (!done) begin
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL stream_valid: out_valid=%b at t=%0d want 1", out_valid, idx);
        done = 1'b1;
      end else begin
        exp_last = (idx == 79);
        checks += 4;
        if (out_t !== 7'(idx)) begin
          failures++; $display("FAIL out_t: got %0d want %0d", out_t, idx);
        end
        if (out_w !== gw[idx]) begin
          failures++; $display("FAIL out_w t=%0d: got %h want %h", idx, out_w, gw[idx]);
        end
        if (out_last !== exp_last) begin
          failures++; $display("FAIL out_last t=%0d: got %b want %b", idx, out_last, exp_last);
        end
        if (in_ready !== 1'b0) begin
          failures++; $display("FAIL in_ready_emit t=%0d: got %b want 0", idx, in_ready);
        end
        cap[idx] = out_w;
        if (idx == stop_at) begin
          out_ready = 1'b1;
          done = 1'b1;
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (out_ready) idx++;
          @(negedge clk);
          cyc++;
          if (idx == 80) begin
            checks += 3;
            if (out_valid !== 1'b0) begin
              failures++; $display("FAIL post_last_valid: got %b want 0", out_valid);
            end
            if (in_ready !== 1'b1) begin
              failures++; $display("FAIL post_last_ready: got %b want 1", in_ready);
            end
            if (out_last !== 1'b0) begin
              failures++; $display("FAIL post_last_last: got %b want 0", out_last);
            end
            done = 1'b1;
          end else if (cyc > 1000) begin
            checks++; failures++;
            $display("FAIL stream_timeout: stuck at t=%0d want 80 beats", idx);
            done = 1'b1;
          end
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_t !== 7'd0)      begin failures++; $display("FAIL reset_out_t: got %0d want 0", out_t); end
    if (out_last !== 1'b0)   begin failures++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    if (out_w !== 32'h0)     begin failures++; $display("FAIL reset_out_w: got %h want 0", out_w); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sha1_abc();
    send_block(abc_block(), 1'b0);
    run_stream(-1, 1'b0);
    checks += 4;
    if (cap[16] !== 32'hC2C4C700) begin failures++; $display("FAIL abc1_w16: got %h want c2c4c700", cap[16]); end
    if (cap[17] !== 32'h00000000) begin failures++; $display("FAIL abc1_w17: got %h want 00000000", cap[17]); end
    if (cap[18] !== 32'h00000030) begin failures++; $display("FAIL abc1_w18: got %h want 00000030", cap[18]); end
    if (cap[19] !== 32'h85898E01) begin failures++; $display("FAIL abc1_w19: got %h want 85898e01", cap[19]); end
  endtask

  task automatic test_sha0_abc();
    logic [511:0] blk;
    blk = abc_block();
    send_block(blk, 1'b1);
    run_stream(-1, 1'b0);
    checks += 2;
    if (cap[16] !== 32'h61626380) begin failures++; $display("FAIL abc0_w16: got %h want 61626380", cap[16]); end
    if (cap[18] !== 32'h00000018) begin failures++; $display("FAIL abc0_w18: got %h want 00000018", cap[18]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[i] !== blk[511-32*i -: 32]) begin
        failures++; $display("FAIL abc0_input_w%0d: got %h want %h", i, cap[i], blk[511-32*i -: 32]);
      end
    end
  endtask

  task automatic test_wpc2();
    int b = 0;
    bit exp_last;
    build_gold(abc_block(), 1'b0);
    checks++;
    if (in_ready2 !== 1'b1) begin failures++; $display("FAIL wpc2_ready: got %b want 1", in_ready2); end
    in_block2 = abc_block(); in_valid2 = 1'b1; out_ready2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    while (b < 40) begin
      checks++;
      if (out_valid2 !== 1'b1) begin
        failures++; $display("FAIL wpc2_valid: got %b at beat %0d want 1", out_valid2, b);
        b = 40;
      end else begin
        exp_last = (b == 39);
        checks += 3;
        if (out_t2 !== 7'(2*b)) begin failures++; $display("FAIL wpc2_t: got %0d want %0d", out_t2, 2*b); end
        if (out_w2 !== {gw[2*b+1], gw[2*b]}) begin
          failures++; $display("FAIL wpc2_w beat %0d: got %h want %h", b, out_w2, {gw[2*b+1], gw[2*b]});
        end
        if (out_last2 !== exp_last) begin failures++; $display("FAIL wpc2_last beat %0d: got %b want %b", b, out_last2, exp_last); end
        if (b == 8) begin
          checks++;
          if (out_w2 !== 64'h00000000_C2C4C700 || out_t2 !== 7'd16) begin
            failures++; $display("FAIL wpc2_beat8: got %h t=%0d want 00000000c2c4c700 t=16", out_w2, out_t2);
          end
        end
        b++;
        @(negedge clk);
      end
    end
    checks++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
      failures++; $display("FAIL wpc2_end: out_valid=%b in_ready=%b want 0/1", out_valid2, in_ready2);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      send_block(rand_block(), 1'($urandom_range(0, 1)));
      run_stream(-1, 1'b1);
    end
  endtask

  task automatic test_abort();
    send_block(rand_block(), 1'b0);
    run_stream(37, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    if (out_t !== 7'd0)     begin failures++; $display("FAIL abort_t: got %0d want 0", out_t); end
    in_block = rand_block(); in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_idle_accept: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    send_block(rand_block(), 1'b0);
    run_stream(-1, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    send_block(rand_block(), 1'b0);
    run_stream(50, 1'b0);
    reset = 1'b1;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    if (out_t !== 7'd0)     begin failures++; $display("FAIL rst_mid_t: got %0d want 0", out_t); end
    if (out_w !== 32'h0)    begin failures++; $display("FAIL rst_mid_w: got %h want 0", out_w); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_block(rand_block(), 1'b1);
    run_stream(-1, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_block = '0; in_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_block2 = '0; out_ready2 = 1'b1;
    test_reset();
    test_sha1_abc();
    test_sha0_abc();
    test_wpc2();
    test_back_to_back();
    test_abort();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
